ram_stream_reader: RTL and testbench

- Read-side sequencer for the team's simple dual-port RAM, which has a synchronous write port and an asynchronous (combinational) read port.
- On a start command, walks a contiguous address window and drives raddr; the RAM returns rdata in the same cycle.
- Each word is registered and presented on a valid/ready output stream toward downstream consumers (UART TX, display, checker).
- Turns the RAM into a burst source with backpressure.

---
 rtl/ram_stream_reader.sv | 137 +++++++++++++
 tb/tb_ram_stream_reader.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_stream_reader.sv
// ram_stream_reader
//   Read-side sequencer for a simple dual-port RAM with a combinational read
//   port. A start command walks a contiguous (wrapping) address window. Each
//   word is registered onto a valid/ready stream with backpressure.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start                one-cycle command pulse, sampled only in IDLE
//   start_addr, len      burst window (len = 0 .. 2**ADDR_WIDTH words)
//   raddr / rdata        RAM read address / combinational read data
//   m_data, m_valid      registered output stream
//   m_ready              consumer ready
//   busy                 burst in progress
//   done                 one-cycle completion pulse
//   checksum             XOR of handshaken words (only with READER_CKSUM_EN)
//
// Optional feature: define READER_CKSUM_EN to add the checksum port.
module ram_stream_reader #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done
`ifdef READER_CKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] checksum
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_FLUSH  = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   REM_ONE  = 1;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   addr, addr_nxt;
  logic [ADDR_WIDTH:0]     remain, remain_nxt;
  logic [DATA_WIDTH-1:0]   data_nxt;
  logic                    valid_nxt, busy_nxt, done_nxt;
  logic                    slot_free;
  logic                    accept;

  // Output register can take a new word if it is empty or being drained now.
  assign slot_free = !m_valid || m_ready;
  assign accept    = (state == S_IDLE) && start && (len != '0);
  assign raddr     = addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      addr    <= '0;
      remain  <= '0;
      m_data  <= '0;
      m_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      addr    <= addr_nxt;
      remain  <= remain_nxt;
      m_data  <= data_nxt;
      m_valid <= valid_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    addr_nxt   = addr;
    remain_nxt = remain;
    data_nxt   = m_data;
    valid_nxt  = m_valid;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            addr_nxt   = start_addr;
            remain_nxt = len;
            busy_nxt   = 1'b1;
            state_nxt  = S_STREAM;
          end else begin
            // Empty burst completes immediately without touching the stream.
            done_nxt = 1'b1;
          end
        end
      end
      S_STREAM: begin
        if (slot_free && (remain != '0)) begin
          data_nxt   = rdata;
          valid_nxt  = 1'b1;
          addr_nxt   = addr + ADDR_ONE;   // wraps modulo depth
          remain_nxt = remain - REM_ONE;
          if (remain == REM_ONE) state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (m_valid && m_ready) begin
          valid_nxt = 1'b0;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef READER_CKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= '0;
    end else if (m_valid && m_ready) begin
      checksum <= checksum ^ m_data;
    end
  end
`endif

endmodule

// File: tb/tb_ram_stream_reader.sv
// Self-checking bench for ram_stream_reader: directed bursts against a
// preloaded RAM model (ram[i] = A0+i); expected words go into a queue that a
// negedge monitor drains on each handshake.
module tb_ram_stream_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] start_addr;
  logic [4:0] len;
  logic [3:0] raddr;
  logic [7:0] rdata;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       busy;
  logic       done;
`ifdef READER_CKSUM_EN
  logic [7:0] checksum;
`endif

  logic [7:0] ram [16];
  logic [7:0] exp_q [$];
  int total = 0;
  int bad   = 0;
  bit       hold_v = 1'b0;
  logic [7:0] hold_d = '0;

  always #5 clk = ~clk;

  assign rdata = ram[raddr];

  ram_stream_reader #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .start_addr(start_addr),
    .len       (len),
    .raddr     (raddr),
    .rdata     (rdata),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .busy      (busy),
    .done      (done)
`ifdef READER_CKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pops on every handshake, checks hold under backpressure.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("hold_valid", 32'(m_valid), 32'd1);
        chk("hold_data", 32'(m_data), 32'(hold_d));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_word: got %0h want none", m_data);
        end else begin
          chk("word", 32'(m_data), 32'(exp_q.pop_front()));
        end
      end
      hold_v = m_valid && !m_ready;
      hold_d = m_data;
    end
  end

  task automatic do_start(input logic [3:0] a, input logic [4:0] l, input bit expect_words);
    start      = 1'b1;
    start_addr = a;
    len        = l;
    if (expect_words)
      for (int unsigned i = 0; i < l; i++) begin
        logic [3:0] idx;
        idx = a + 4'(i);
        exp_q.push_back(8'hA0 + 8'(idx));
      end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget, output int n);
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (done) return;
      if (n >= budget) begin
        total++;
        bad++;
        $display("FAIL %s_timeout: got no done want done within %0d cycles", name, budget);
        return;
      end
    end
  endtask

  initial begin
    int n;
    bit [3:0] pat;
    for (int i = 0; i < 16; i++) ram[i] = 8'hA0 + 8'(i);
    start = 1'b0; start_addr = '0; len = '0; m_ready = 1'b1;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_busy",  32'(busy),    32'd0);
    chk("rst_done",  32'(done),    32'd0);
    chk("rst_data",  32'(m_data),  32'd0);
    chk("rst_raddr", 32'(raddr),   32'd0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic burst: A2,A3,A4; done 5 negedges after start is taken.
    do_start(4'd2, 5'd3, 1'b1);
    chk("basic_busy", 32'(busy), 32'd1);
    wait_done("basic", 20, n);
    chk("basic_done_lat", 32'(n), 32'd5);
    chk("basic_busy_drop", 32'(busy), 32'd0);
    chk("basic_q_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    chk("done_pulse", 32'(done), 32'd0);

    // Wrap-around: raddr 14,15,0,1,2.
    do_start(4'd14, 5'd4, 1'b1);
    chk("wrap_raddr0", 32'(raddr), 32'd14);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      chk("wrap_raddr", 32'(raddr), 32'((14 + i) % 16));
    end
    wait_done("wrap", 10, n);
    chk("wrap_q_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;

    // Full depth with backpressure pattern 1,0,0,1.
    pat = 4'b1001;
    do_start(4'd0, 5'd16, 1'b1);
    n = 0;
    while (n < 200) begin
      m_ready = pat[n % 4];
      @(negedge clk);
      if (done) break;
      @(posedge clk); #1;
      n++;
    end
    chk("bp_done", 32'(done), 32'd1);
    chk("bp_q_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    m_ready = 1'b1;

    // Zero length: done next cycle, no stream activity.
    do_start(4'd3, 5'd0, 1'b1);
    wait_done("zero", 10, n);
    chk("zero_done_lat", 32'(n), 32'd1);
    chk("zero_valid", 32'(m_valid), 32'd0);
    @(posedge clk); #1;

    // Start while busy is ignored.
    do_start(4'd0, 5'd4, 1'b1);
    @(posedge clk); #1;
    do_start(4'd5, 5'd2, 1'b0);
    wait_done("ignore", 20, n);
    repeat (6) @(posedge clk);
    #1;
    chk("ignore_q_empty", 32'(exp_q.size()), 32'd0);
    chk("ignore_idle_valid", 32'(m_valid), 32'd0);

    // Reset during 2nd word of a len=8 burst.
    do_start(4'd0, 5'd8, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_word2", 32'(m_data), 32'hA1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_busy",  32'(busy),    32'd0);
    chk("mid_rst_done",  32'(done),    32'd0);
    exp_q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    do_start(4'd0, 5'd1, 1'b1);
    wait_done("post_rst", 10, n);
    chk("post_rst_lat", 32'(n), 32'd3);
    chk("post_rst_q_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;

`ifdef READER_CKSUM_EN
    do_start(4'd0, 5'd4, 1'b1);
    wait_done("ck1", 20, n);
    @(posedge clk); #1;
    chk("cksum_0_4", 32'(checksum), 32'h00);
    do_start(4'd1, 5'd3, 1'b1);
    wait_done("ck2", 20, n);
    @(posedge clk); #1;
    chk("cksum_1_3", 32'(checksum), 32'hA0);
`endif

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
